// File: rtl/req_encoder_pkg.sv
// enc_pkg: shared FSM state type and code-width helper for the request encoder
package enc_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic int code_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/req_encoder_if.sv
// req_encoder_if: request/code handshake bundle between request sources and the encoder
interface req_encoder_if #(
  parameter int N = 4
) ();
  localparam int W = enc_pkg::code_w(N);
  logic [N-1:0] req;
  logic         code_ack;
  logic         code_valid;
  logic [W-1:0] code;
  logic [N-1:0] grant;
  logic [N-1:0] pending;
  logic         overflow;
  modport master (output req, code_ack, input code_valid, code, grant, pending, overflow);
  modport slave (input req, code_ack, output code_valid, code, grant, pending, overflow);
endinterface

// File: rtl/req_encoder_prio_enc.sv
// prio_enc: combinational priority encoder, lowest set bit wins
module prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] in_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  // scan from the top down so the lowest set index is written last
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) idx_o = in_i[i] ? W'(i) : idx_o;
  end
  assign any_o = |in_i;
endmodule

// File: rtl/req_encoder.sv
// req_encoder: captures request edges, priority-encodes pending events, serves one code per valid/ack handshake
module req_encoder import enc_pkg::*; #(
  parameter int N = 4
) (
  input logic          clk,
  input logic          rst_n,
  req_encoder_if.slave bus
);
  localparam int W = code_w(N);
  state_t       state_q, state_d;
  logic [N-1:0] req_q, pending_q, pending_d, rise, clear_mask;
  logic [W-1:0] code_q, code_d, idx;
  logic         any, ack_fire, overflow_q, overflow_d;
  prio_enc #(.N(N), .W(W)) u_prio (.in_i(pending_q), .idx_o(idx), .any_o(any));
  // edge capture into pending; a fresh edge in the ack cycle wins over the clear
  always_comb begin
    rise       = bus.req & ~req_q;
    ack_fire   = (state_q == HOLD) & bus.code_ack;
    clear_mask = ack_fire ? N'(1) << code_q : '0;
    pending_d  = (pending_q & ~clear_mask) | rise;
    overflow_d = |(rise & pending_q & ~clear_mask);
  end
  // load the lowest pending index when idle, freeze it until acknowledged
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (state_q == IDLE && any) begin
      state_d = HOLD;
      code_d  = idx;
    end else if (ack_fire) begin
      state_d = IDLE;
    end
  end
  // state registers; req_q clears on reset so a held request counts as a new edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= '0;
      req_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      req_q      <= bus.req;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.code_valid = (state_q == HOLD);
  assign bus.code       = code_q;
  assign bus.grant      = (state_q == HOLD) ? N'(1) << code_q : '0;
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_req_encoder.sv
// tb_req_encoder: directed scenarios plus random traffic against an event-level reference model
module tb_req_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  req_encoder_if #(.N(4)) bus ();
  req_encoder #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  bit m_prev[4];
  bit m_pend[4];
  bit m_busy;
  int m_code;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pend_vec();
    logic [3:0] v = '0;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model(input logic [3:0] r, input logic a, input logic rn);
    bit nxt[4];
    int low = -1;
    bit acked;
    if (!rn) begin
      foreach (m_pend[i]) begin m_pend[i] = 0; m_prev[i] = 0; end
      m_busy = 0; m_code = 0; m_ovf = 0;
      return;
    end
    acked = m_busy && a;
    m_ovf = 0;
    for (int i = 0; i < 4; i++) begin
      bit edge_i = r[i] && !m_prev[i];
      bit served = acked && (m_code == i);
      if (m_pend[i] && low < 0) low = i;
      nxt[i] = edge_i || (m_pend[i] && !served);
      if (edge_i && m_pend[i] && !served) m_ovf = 1;
    end
    if (m_busy) begin
      if (acked) m_busy = 0;
    end else if (low >= 0) begin
      m_busy = 1;
      m_code = low;
    end
    for (int i = 0; i < 4; i++) begin m_pend[i] = nxt[i]; m_prev[i] = r[i]; end
  endtask

  task automatic step(input logic [3:0] r, input logic a, input logic rn);
    bus.req = r;
    bus.code_ack = a;
    rst_n = rn;
    @(posedge clk);
    model(r, a, rn);
    #1;
    check("valid", 32'(bus.code_valid), 32'(m_busy));
    check("code", 32'(bus.code), 32'(m_code));
    check("grant", 32'(bus.grant), m_busy ? 32'(1) << m_code : 32'd0);
    check("pending", 32'(bus.pending), 32'(pend_vec()));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  initial begin
    bus.req = '0;
    bus.code_ack = 1'b0;
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    check("rst_valid", 32'(bus.code_valid), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    // 1: single pulse, latency, hold, ack
    step(4'b0100, 0, 1);
    check("t1_pend", 32'(bus.pending), 32'h4);
    check("t1_notyet", 32'(bus.code_valid), 32'd0);
    step(4'b0000, 0, 1);
    check("t1_valid", 32'(bus.code_valid), 32'd1);
    check("t1_code", 32'(bus.code), 32'd2);
    check("t1_grant", 32'(bus.grant), 32'h4);
    repeat (5) step(4'b0000, 0, 1);
    check("t1_hold", 32'(bus.code), 32'd2);
    step(4'b0000, 1, 1);
    check("t1_ackpend", 32'(bus.pending), 32'd0);
    check("t1_ackvalid", 32'(bus.code_valid), 32'd0);
    step(4'b0000, 0, 1);
    // 2: two simultaneous edges served lowest first
    step(4'b1010, 0, 1);
    step(4'b0000, 0, 1);
    check("t2_first", 32'(bus.code), 32'd1);
    step(4'b0000, 1, 1);
    step(4'b0000, 0, 1);
    check("t2_second", 32'(bus.code), 32'd3);
    // 3: no preemption in HOLD
    step(4'b0001, 0, 1);
    step(4'b0000, 0, 1);
    check("t3_nopreempt", 32'(bus.code), 32'd3);
    step(4'b0000, 1, 1);
    step(4'b0000, 0, 1);
    check("t3_next", 32'(bus.code), 32'd0);
    step(4'b0000, 1, 1);
    step(4'b0000, 0, 1);
    // 4: overflow on repeated edge of pending bit
    step(4'b0001, 0, 1);
    step(4'b0100, 0, 1);
    step(4'b0000, 0, 1);
    step(4'b0100, 0, 1);
    check("t4_ovf", 32'(bus.overflow), 32'd1);
    step(4'b0000, 0, 1);
    check("t4_ovf_pulse", 32'(bus.overflow), 32'd0);
    repeat (2) begin step(4'b0000, 1, 1); step(4'b0000, 0, 1); end
    step(4'b0000, 0, 1);
    // 5: edge in ack cycle re-arms the same code
    step(4'b0010, 0, 1);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 1);
    step(4'b0010, 1, 1);
    check("t5_pend", 32'(bus.pending), 32'h2);
    check("t5_noovf", 32'(bus.overflow), 32'd0);
    step(4'b0000, 0, 1);
    check("t5_again", 32'(bus.code), 32'd1);
    step(4'b0000, 1, 1);
    step(4'b0000, 0, 1);
    // 6: reset during HOLD, held req counts once afterwards
    step(4'b1100, 0, 1);
    step(4'b1100, 0, 1);
    step(4'b1100, 0, 0);
    check("t6_valid", 32'(bus.code_valid), 32'd0);
    check("t6_pend", 32'(bus.pending), 32'd0);
    check("t6_grant", 32'(bus.grant), 32'd0);
    step(4'b1000, 0, 1);
    step(4'b1000, 0, 1);
    check("t6_code", 32'(bus.code), 32'd3);
    step(4'b1000, 1, 1);
    step(4'b1000, 0, 1);
    check("t6_once", 32'(bus.code_valid), 32'd0);
    // random traffic
    for (int n = 0; n < 3000; n++)
      step(4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) != 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
